// File: rtl/noc_pkg.sv
// Shared router types and default sizing for the switch allocator.
package noc_pkg;

  localparam int unsigned DEF_VID_BITS  = 6;
  localparam int unsigned DEF_PORTS     = 5;
  localparam int unsigned DEF_CHANNELS  = 12;
  localparam int unsigned DEF_BUF_DEPTH = 4;
  localparam int unsigned DEF_NUM_REQ   = DEF_PORTS * DEF_CHANNELS;
  localparam int unsigned CRED_W        = $clog2(DEF_BUF_DEPTH + 1);

  typedef logic [DEF_VID_BITS-1:0] vid_t;
  typedef logic [CRED_W-1:0]       credit_t;

  // Round-robin pointer advance: one past the winner, wrapping at n.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return ((v + 1) >= n) ? 0 : (v + 1);
  endfunction

endpackage

// File: rtl/sw_alloc_if.sv
// Request/grant/credit bundle between VC input logic, allocator and crossbar.
// Optional credit_err signal present when SW_ALLOC_CREDIT_CHECK_EN is defined.
interface sw_alloc_if import noc_pkg::*; #(
  parameter int unsigned VID_BITS = DEF_VID_BITS,
  parameter int unsigned NUM_REQ  = DEF_NUM_REQ
);

  logic [NUM_REQ-1:0]  sa_req;
  logic [VID_BITS-1:0] sa_ovid [NUM_REQ];
  logic [NUM_REQ-1:0]  credit_ret;
  logic [NUM_REQ-1:0]  sa_gnt;
  logic [VID_BITS-1:0] g_ovid [NUM_REQ];
  logic [NUM_REQ-1:0]  cred_avail;

`ifdef SW_ALLOC_CREDIT_CHECK_EN
  logic credit_err;

  modport master (
    output sa_req, sa_ovid, credit_ret,
    input  sa_gnt, g_ovid, cred_avail, credit_err
  );

  modport slave (
    input  sa_req, sa_ovid, credit_ret,
    output sa_gnt, g_ovid, cred_avail, credit_err
  );
`else
  modport master (
    output sa_req, sa_ovid, credit_ret,
    input  sa_gnt, g_ovid, cred_avail
  );

  modport slave (
    input  sa_req, sa_ovid, credit_ret,
    output sa_gnt, g_ovid, cred_avail
  );
`endif

endinterface

// File: rtl/rr_arb.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arb import noc_pkg::*; #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic        w_found;
  int unsigned w_idx;

  // Scan from the pointer, wrapping once around the request vector.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      w_idx = (32'(ptr) + k) % N;
      if (!w_found && req[w_idx]) begin
        w_found      = 1'b1;
        gnt[w_idx]   = 1'b1;
        gnt_idx      = IW'(w_idx);
      end
    end
  end

endmodule

// File: rtl/sw_alloc.sv
// Separable input-first switch allocator with per-output-VC credit counters.
// Define SW_ALLOC_CREDIT_CHECK_EN to add the sticky credit_err overflow flag.
module sw_alloc import noc_pkg::*; #(
  parameter int unsigned VID_BITS  = DEF_VID_BITS,
  parameter int unsigned PORTS     = DEF_PORTS,
  parameter int unsigned CHANNELS  = DEF_CHANNELS,
  parameter int unsigned BUF_DEPTH = DEF_BUF_DEPTH
) (
  input  logic       clk,
  input  logic       rst_n,
  sw_alloc_if.slave  bus
);

  localparam int unsigned NUM_REQ = PORTS * CHANNELS;
  localparam int unsigned CW      = $clog2(BUF_DEPTH + 1);
  localparam int unsigned CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned PT_W    = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int unsigned OV_SPAN = 2 ** VID_BITS;

  logic [CW-1:0]       r_cred     [NUM_REQ];
  logic [CW-1:0]       w_cred_nxt [NUM_REQ];
  logic [CH_W-1:0]     r_in_ptr   [PORTS];
  logic [PT_W-1:0]     r_out_ptr  [NUM_REQ];
  logic [NUM_REQ-1:0]  r_gnt;
  logic [NUM_REQ-1:0]  r_avail;
  logic [VID_BITS-1:0] r_g_ovid   [NUM_REQ];

  logic [OV_SPAN-1:0]  w_cnz;
  logic [NUM_REQ-1:0]  w_elig;
  logic [NUM_REQ-1:0]  w_gnt;
  logic [NUM_REQ-1:0]  w_dec;
  logic [CHANNELS-1:0] w_s1_gnt   [PORTS];
  logic [CH_W-1:0]     w_s1_idx   [PORTS];
  logic [PORTS-1:0]    w_s1_val;
  logic [VID_BITS-1:0] w_s1_ovid  [PORTS];
  logic [PORTS-1:0]    w_s2_req   [NUM_REQ];
  logic [PORTS-1:0]    w_s2_gnt   [NUM_REQ];
  logic [PT_W-1:0]     w_s2_idx   [NUM_REQ];
  logic [PORTS-1:0]    w_port_win;

  // Eligibility: valid target id and a free downstream slot. The nonzero map
  // spans every encodable id so out-of-range targets read a hard zero.
  always_comb begin
    w_cnz = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      w_cnz[j] = (r_cred[j] != '0);
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_elig[i] = bus.sa_req[i] && (32'(bus.sa_ovid[i]) < NUM_REQ) && w_cnz[bus.sa_ovid[i]];
    end
  end

  // Stage 1: one candidate VC per input port.
  for (genvar p = 0; p < PORTS; p++) begin : g_in
    rr_arb #(.N(CHANNELS), .IW(CH_W)) u_in_arb (
      .req     (w_elig[p*CHANNELS +: CHANNELS]),
      .ptr     (r_in_ptr[p]),
      .gnt     (w_s1_gnt[p]),
      .gnt_idx (w_s1_idx[p])
    );
    assign w_s1_val[p]  = |w_s1_gnt[p];
    assign w_s1_ovid[p] = bus.sa_ovid[p*CHANNELS + 32'(w_s1_idx[p])];
    assign w_gnt[p*CHANNELS +: CHANNELS] = w_port_win[p] ? w_s1_gnt[p] : '0;
  end

  // Route each port's stage-1 winner to the arbiter of its target output VC.
  always_comb begin
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      for (int unsigned p = 0; p < PORTS; p++) begin
        w_s2_req[j][p] = w_s1_val[p] && (32'(w_s1_ovid[p]) == j);
      end
    end
  end

  // Stage 2: one winning port per output VC.
  for (genvar j = 0; j < NUM_REQ; j++) begin : g_out
    rr_arb #(.N(PORTS), .IW(PT_W)) u_out_arb (
      .req     (w_s2_req[j]),
      .ptr     (r_out_ptr[j]),
      .gnt     (w_s2_gnt[j]),
      .gnt_idx (w_s2_idx[j])
    );
    assign w_dec[j] = |w_s2_gnt[j];
  end

  // A port holds a final grant if any output arbiter picked it.
  always_comb begin
    w_port_win = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      w_port_win = w_port_win | w_s2_gnt[j];
    end
  end

  // Next credit count: grant consumes, return refills, saturating at depth.
  always_comb begin
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      w_cred_nxt[j] = r_cred[j];
      if (w_dec[j] && !bus.credit_ret[j]) begin
        w_cred_nxt[j] = r_cred[j] - CW'(1);
      end else if (!w_dec[j] && bus.credit_ret[j] && (r_cred[j] != CW'(BUF_DEPTH))) begin
        w_cred_nxt[j] = r_cred[j] + CW'(1);
      end
    end
  end

  // Registered grants and crossbar selects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) r_g_ovid[i] <= '0;
    end else begin
      r_gnt <= w_gnt;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        r_g_ovid[i] <= w_gnt[i] ? bus.sa_ovid[i] : '0;
      end
    end
  end

  // Round-robin pointers advance only on final grants.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned p = 0; p < PORTS; p++) r_in_ptr[p] <= '0;
      for (int unsigned j = 0; j < NUM_REQ; j++) r_out_ptr[j] <= '0;
    end else begin
      for (int unsigned p = 0; p < PORTS; p++) begin
        if (w_port_win[p]) r_in_ptr[p] <= CH_W'(wrap_inc(32'(w_s1_idx[p]), CHANNELS));
      end
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (w_dec[j]) r_out_ptr[j] <= PT_W'(wrap_inc(32'(w_s2_idx[j]), PORTS));
      end
    end
  end

  // Credit counters and their registered nonzero flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned j = 0; j < NUM_REQ; j++) r_cred[j] <= CW'(BUF_DEPTH);
      r_avail <= '1;
    end else begin
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        r_cred[j]  <= w_cred_nxt[j];
        r_avail[j] <= (w_cred_nxt[j] != '0);
      end
    end
  end

  assign bus.sa_gnt     = r_gnt;
  assign bus.g_ovid     = r_g_ovid;
  assign bus.cred_avail = r_avail;

`ifdef SW_ALLOC_CREDIT_CHECK_EN
  logic r_credit_err;
  logic w_ovf;

  // A return into an already full counter means upstream lost track of credits.
  always_comb begin
    w_ovf = 1'b0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (bus.credit_ret[j] && (r_cred[j] == CW'(BUF_DEPTH))) w_ovf = 1'b1;
    end
  end

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_credit_err <= 1'b0;
    else if (w_ovf) r_credit_err <= 1'b1;
  end

  assign bus.credit_err = r_credit_err;
`endif

endmodule

// File: tb/tb_sw_alloc.sv
// Bench for sw_alloc: hand-derived vector table, reset corner cases and a
// randomized phase checked against a behavioural allocator model.
module tb_sw_alloc;
  import noc_pkg::*;

  localparam int NR = int'(DEF_NUM_REQ);
  localparam int CH = int'(DEF_CHANNELS);
  localparam int NP = int'(DEF_PORTS);
  localparam int BD = int'(DEF_BUF_DEPTH);
  localparam int VB = int'(DEF_VID_BITS);

  typedef struct {
    bit rst;
    int a_vc; int a_ov;
    int b_vc; int b_ov;
    int c_vc; int c_ov;
    int ret_j;
    int exp_vc; int exp_ov;
    int zero_j;
  } vec_t;

  typedef struct packed {
    logic [NR-1:0]    gnt;
    logic [NR*VB-1:0] ovid;
    logic [NR-1:0]    avail;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_vec;
  int   n_err;
  exp_t sb_q[$];
  vec_t tbl[$];

  int m_cred    [NR];
  int m_in_ptr  [NP];
  int m_out_ptr [NR];

  always #5 clk = ~clk;

  sw_alloc_if bus ();

  sw_alloc u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic clear_inputs();
    bus.sa_req     = '0;
    bus.credit_ret = '0;
    for (int i = 0; i < NR; i++) bus.sa_ovid[i] = '0;
  endtask

  task automatic cmp_vec(input string nm, input logic [NR-1:0] got, input logic [NR-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic cmp_ovid(input string nm, input logic [NR*VB-1:0] exp);
    logic [NR*VB-1:0] got;
    for (int i = 0; i < NR; i++) got[i*VB +: VB] = bus.g_ovid[i];
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic cmp_bit(input string nm, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  task automatic check_out(input exp_t e, input string nm);
    cmp_vec({nm, " sa_gnt"}, bus.sa_gnt, e.gnt);
    cmp_vec({nm, " cred_avail"}, bus.cred_avail, e.avail);
    cmp_ovid({nm, " g_ovid"}, e.ovid);
  endtask

  // Push the expectation, let the DUT register one decision, then score it.
  task automatic apply(input exp_t e, input string nm);
    exp_t got_e;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got_e = sb_q.pop_front();
    check_out(got_e, nm);
  endtask

  task automatic model_reset();
    for (int j = 0; j < NR; j++) begin
      m_cred[j]    = BD;
      m_out_ptr[j] = 0;
    end
    for (int p = 0; p < NP; p++) m_in_ptr[p] = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    @(posedge clk);
    #1;
    cmp_vec("reset sa_gnt", bus.sa_gnt, '0);
    cmp_vec("reset cred_avail", bus.cred_avail, '1);
    cmp_ovid("reset g_ovid", '0);
`ifdef SW_ALLOC_CREDIT_CHECK_EN
    cmp_bit("reset credit_err", bus.credit_err, 1'b0);
`endif
    rst_n = 1'b1;
    model_reset();
  endtask

  function automatic vec_t mk(input bit rst, input int av, input int ao, input int bv, input int bo,
                              input int cv, input int co, input int rj, input int ev, input int eo,
                              input int zj);
    vec_t v;
    v.rst = rst; v.a_vc = av; v.a_ov = ao; v.b_vc = bv; v.b_ov = bo;
    v.c_vc = cv; v.c_ov = co; v.ret_j = rj; v.exp_vc = ev; v.exp_ov = eo; v.zero_j = zj;
    return v;
  endfunction

  function automatic exp_t vec_exp(input vec_t v);
    exp_t e;
    e.gnt   = '0;
    e.ovid  = '0;
    e.avail = '1;
    if (v.exp_vc >= 0) begin
      e.gnt[v.exp_vc]             = 1'b1;
      e.ovid[v.exp_vc*VB +: VB]   = VB'(v.exp_ov);
    end
    if (v.zero_j >= 0) e.avail[v.zero_j] = 1'b0;
    return e;
  endfunction

  task automatic drive_vec(input vec_t v);
    clear_inputs();
    if (v.a_vc >= 0) begin bus.sa_req[v.a_vc] = 1'b1; bus.sa_ovid[v.a_vc] = VB'(v.a_ov); end
    if (v.b_vc >= 0) begin bus.sa_req[v.b_vc] = 1'b1; bus.sa_ovid[v.b_vc] = VB'(v.b_ov); end
    if (v.c_vc >= 0) begin bus.sa_req[v.c_vc] = 1'b1; bus.sa_ovid[v.c_vc] = VB'(v.c_ov); end
    if (v.ret_j >= 0) bus.credit_ret[v.ret_j] = 1'b1;
  endtask

  // Behavioural iSLIP step: port pass, then output pass, then credit update.
  function automatic exp_t model_step(input logic [NR-1:0] req, input logic [NR*VB-1:0] ovf,
                                      input logic [NR-1:0] ret);
    exp_t          e;
    int            win_c [NP];
    bit            has_w [NP];
    logic [NR-1:0] elig;
    logic [NR-1:0] dec;
    int            ov, c, q, i, cnt;
    bit            done;
    e.gnt = '0; e.ovid = '0; e.avail = '0; dec = '0;
    for (int k = 0; k < NR; k++) begin
      ov      = int'(ovf[k*VB +: VB]);
      elig[k] = 1'b0;
      if (req[k] && ov < NR) elig[k] = (m_cred[ov] > 0);
    end
    for (int p = 0; p < NP; p++) begin
      has_w[p] = 1'b0;
      win_c[p] = 0;
      for (int k = 0; k < CH; k++) begin
        c = (m_in_ptr[p] + k) % CH;
        if (!has_w[p] && elig[p*CH + c]) begin
          has_w[p] = 1'b1;
          win_c[p] = c;
        end
      end
    end
    for (int j = 0; j < NR; j++) begin
      done = 1'b0;
      for (int k = 0; k < NP; k++) begin
        q = (m_out_ptr[j] + k) % NP;
        i = q*CH + win_c[q];
        if (!done && has_w[q] && int'(ovf[i*VB +: VB]) == j) begin
          done               = 1'b1;
          e.gnt[i]           = 1'b1;
          e.ovid[i*VB +: VB] = ovf[i*VB +: VB];
          dec[j]             = 1'b1;
          m_in_ptr[q]        = (win_c[q] + 1) % CH;
          m_out_ptr[j]       = (q + 1) % NP;
        end
      end
    end
    for (int j = 0; j < NR; j++) begin
      cnt = m_cred[j] - int'(dec[j]) + int'(ret[j]);
      if (cnt > BD) cnt = BD;
      m_cred[j]  = cnt;
      e.avail[j] = (cnt > 0);
    end
    return e;
  endfunction

  initial begin
    logic [NR-1:0]    r_req;
    logic [NR-1:0]    r_ret;
    logic [NR*VB-1:0] r_ov;
    n_vec = 0;
    n_err = 0;
    clear_inputs();
    model_reset();

    // Single grant, credit exhaustion and a returned credit on ovid 7.
    tbl.push_back(mk(1, 0, 7, -1, 0, -1, 0, -1,  0, 7, -1));
    tbl.push_back(mk(0, 0, 7, -1, 0, -1, 0, -1,  0, 7, -1));
    tbl.push_back(mk(0, 0, 7, -1, 0, -1, 0, -1,  0, 7, -1));
    tbl.push_back(mk(0, 0, 7, -1, 0, -1, 0, -1,  0, 7,  7));
    tbl.push_back(mk(0, 0, 7, -1, 0, -1, 0, -1, -1, 0,  7));
    tbl.push_back(mk(0, 0, 7, -1, 0, -1, 0,  7, -1, 0, -1));
    tbl.push_back(mk(0, 0, 7, -1, 0, -1, 0, -1,  0, 7,  7));
    tbl.push_back(mk(0,-1, 0, -1, 0, -1, 0, -1, -1, 0,  7));
    // Three ports contend for ovid 5 with credits streaming back.
    tbl.push_back(mk(1, 0, 5, 12, 5, 24, 5,  5,  0, 5, -1));
    tbl.push_back(mk(0, 0, 5, 12, 5, 24, 5,  5, 12, 5, -1));
    tbl.push_back(mk(0, 0, 5, 12, 5, 24, 5,  5, 24, 5, -1));
    tbl.push_back(mk(0, 0, 5, 12, 5, 24, 5,  5,  0, 5, -1));
    tbl.push_back(mk(0, 0, 5, 12, 5, 24, 5,  5, 12, 5, -1));
    tbl.push_back(mk(0, 0, 5, 12, 5, 24, 5,  5, 24, 5, -1));
    // Three VCs of port 0 to distinct outputs: one grant per cycle.
    tbl.push_back(mk(1, 0, 3,  1, 4,  2, 5, -1,  0, 3, -1));
    tbl.push_back(mk(0, 0, 3,  1, 4,  2, 5, -1,  1, 4, -1));
    tbl.push_back(mk(0, 0, 3,  1, 4,  2, 5, -1,  2, 5, -1));
    tbl.push_back(mk(0, 0, 3,  1, 4,  2, 5, -1,  0, 3, -1));
    // Out-of-range target never wins; return at full saturates.
    tbl.push_back(mk(1,13,60, -1, 0, -1, 0,  9, -1, 0, -1));
    tbl.push_back(mk(0,13,60, 14, 9, -1, 0, -1, 14, 9, -1));
    tbl.push_back(mk(0,13,60, 14, 9, -1, 0, -1, 14, 9, -1));
    tbl.push_back(mk(0,13,60, 14, 9, -1, 0, -1, 14, 9, -1));
    tbl.push_back(mk(0,13,60, 14, 9, -1, 0, -1, 14, 9,  9));
    tbl.push_back(mk(0,13,60, 14, 9, -1, 0, -1, -1, 0,  9));

    for (int k = 0; k < tbl.size(); k++) begin
      if (tbl[k].rst) do_reset();
      drive_vec(tbl[k]);
      apply(vec_exp(tbl[k]), $sformatf("row%0d", k));
    end
`ifdef SW_ALLOC_CREDIT_CHECK_EN
    cmp_bit("sticky credit_err", bus.credit_err, 1'b1);
`endif

    // Reset mid-stream with one credit left on ovid 7.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive_vec(mk(0, 0, 7, -1, 0, -1, 0, -1, 0, 7, -1));
      apply(vec_exp(mk(0, 0, 7, -1, 0, -1, 0, -1, 0, 7, -1)), $sformatf("prerst%0d", k));
    end
    rst_n = 1'b0;
    #1;
    cmp_vec("midrst sa_gnt", bus.sa_gnt, '0);
    cmp_vec("midrst cred_avail", bus.cred_avail, '1);
    clear_inputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    cmp_vec("postrst cred_avail", bus.cred_avail, '1);
    for (int k = 0; k < 5; k++) begin
      drive_vec(mk(0, 0, 7, -1, 0, -1, 0, -1, 0, 7, -1));
      apply(vec_exp(mk(0, 0, 7, -1, 0, -1, 0, -1, (k < 4) ? 0 : -1, 7, (k >= 3) ? 7 : -1)),
            $sformatf("postrst%0d", k));
    end

    // Random contention on a few hot outputs against the model.
    do_reset();
    for (int t = 0; t < 400; t++) begin
      r_req = '0;
      r_ret = '0;
      r_ov  = '0;
      for (int i = 0; i < NR; i++) begin
        r_req[i] = ($urandom_range(0, 3) == 0);
        r_ov[i*VB +: VB] = ($urandom_range(0, 15) == 0) ? VB'($urandom_range(60, 63))
                                                        : VB'($urandom_range(0, 7));
      end
      for (int j = 0; j < 8; j++) r_ret[j] = ($urandom_range(0, 2) == 0);
      bus.sa_req     = r_req;
      bus.credit_ret = r_ret;
      for (int i = 0; i < NR; i++) bus.sa_ovid[i] = r_ov[i*VB +: VB];
      apply(model_step(r_req, r_ov, r_ret), $sformatf("rand%0d", t));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
